// File: rtl/pipe_stall_pkg.sv
// Shared types and constants for the ID-stage stall sequencer.
// Holds the FSM state encoding and default CGRA timeout.
package pipe_stall_pkg;

    localparam int REG_ADDR_W       = 5;
    localparam int CGRA_TIMEOUT_DEF = 1024;
    localparam int CNT_W_DEF        = 11;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        CG_START,
        CG_WAIT,
        CG_DONE
    } stall_state_e;

endpackage

// File: rtl/lu_hazard_detect.sv
// Load-use hazard comparator between the EX load and the ID sources.
// Purely combinational so the forwarding unit can share it.
module lu_hazard_detect
    import pipe_stall_pkg::*;
(
    input  logic                  mem_read_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic [REG_ADDR_W-1:0] rs1_i,
    input  logic [REG_ADDR_W-1:0] rs2_i,
    input  logic                  uses_rs2_i,
    output logic                  hazard_o
);

    logic rd_nz;
    logic hit_rs1;
    logic hit_rs2;

    assign rd_nz    = (rd_i != '0);
    assign hit_rs1  = (rd_i == rs1_i);
    assign hit_rs2  = uses_rs2_i && (rd_i == rs2_i);
    assign hazard_o = mem_read_i && rd_nz && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/freeze sequencer: load-use bubbles and CGRA offload handshake.
// Optional perf counters are built when STALL_PERF_CNT_EN is defined.
module pipe_stall_ctrl
    import pipe_stall_pkg::*;
#(
    parameter int CGRA_TIMEOUT = CGRA_TIMEOUT_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  IDEX_MemRead_i,
    input  logic [REG_ADDR_W-1:0] IDEX_Rd_i,
    input  logic [REG_ADDR_W-1:0] IFID_Rs1_i,
    input  logic [REG_ADDR_W-1:0] IFID_Rs2_i,
    input  logic                  ID_UsesRs2_i,
    input  logic                  cgra_req_i,
    input  logic                  flush_i,
    input  logic                  cgra_done_i,
    output logic                  Stall_o,
    output logic                  PCWrite_o,
    output logic                  IFIDWrite_o,
    output logic                  cgra_start_o,
    output logic                  cgra_busy_o,
    output logic                  timeout_o
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles_o,
    output logic [15:0]           cgra_ops_o
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CGRA_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    stall_state_e     state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             timeout_q, timeout_d;

    logic lu;
    logic cg_issue;
    logic release_c;

    lu_hazard_detect u_lu (
        .mem_read_i (IDEX_MemRead_i),
        .rd_i       (IDEX_Rd_i),
        .rs1_i      (IFID_Rs1_i),
        .rs2_i      (IFID_Rs2_i),
        .uses_rs2_i (ID_UsesRs2_i),
        .hazard_o   (lu)
    );

    // a wrong-path CGRA opcode never launches; a load-use stall defers it
    assign cg_issue = !lu && cgra_req_i && !flush_i;

    // front end runs only on clean RUN cycles and the CG_DONE release cycle
    always_comb begin
        release_c = 1'b0;
        unique case (state_q)
            RUN:     release_c = !lu && !cg_issue;
            CG_DONE: release_c = 1'b1;
            default: release_c = 1'b0;
        endcase
    end

    assign Stall_o     = !release_c;
    assign PCWrite_o   = release_c;
    assign IFIDWrite_o = release_c;

    assign cgra_start_o = (state_q == CG_START);
    assign cgra_busy_o  = (state_q == CG_START) || (state_q == CG_WAIT);
    assign timeout_o    = timeout_q;

    // next-state, timeout counter and sticky timeout flag
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        timeout_d = timeout_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) state_d = RUN;
            end
            RUN: begin
                if (cg_issue) state_d = CG_START;
            end
            CG_START: begin
                count_d   = '0;
                timeout_d = 1'b0;
                state_d   = cgra_done_i ? CG_DONE : CG_WAIT;
            end
            CG_WAIT: begin
                count_d = count_q + CNT_ONE;
                if (cgra_done_i) begin
                    state_d = CG_DONE;
                end else if (count_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = CG_DONE;
                end
            end
            CG_DONE: begin
                state_d = RUN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            count_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] cgra_ops_q, cgra_ops_d;

    // saturating stall-cycle count and wrapping CGRA launch count
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        cgra_ops_d     = cgra_ops_q;
        if (Stall_o && (state_q != IDLE) && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (state_q == CG_START) begin
            cgra_ops_d = cgra_ops_q + 16'd1;
        end
    end

    // perf counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cycles_q <= '0;
            cgra_ops_q     <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            cgra_ops_q     <= cgra_ops_d;
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign cgra_ops_o     = cgra_ops_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench: dut_a uses an 8-cycle timeout, dut_b the default.
// Both share stimulus; expected outputs are queued per cycle.
module tb_pipe_stall_ctrl;

    typedef struct packed {
        logic       rst;
        logic       start;
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u2;
        logic       req;
        logic       fl;
        logic       dn;
    } in_t;

    typedef struct {
        int         id;
        logic [5:0] ea;
        logic [5:0] eb;
        logic [5:0] m;
        bit         act;
        bit         clr;
        bit         chk;
    } exp_t;

    // {Stall, PCWrite, IFIDWrite, cgra_start, cgra_busy, timeout}
    localparam logic [5:0] V_IDLE = 6'b100000;
    localparam logic [5:0] V_RUN  = 6'b011000;
    localparam logic [5:0] V_FRZ  = 6'b100000;
    localparam logic [5:0] V_CGS  = 6'b100110;
    localparam logic [5:0] V_CGW  = 6'b100010;
    localparam logic [5:0] V_CGD  = 6'b011000;
    localparam logic [5:0] T      = 6'b000001;
    localparam logic [5:0] ALL    = 6'b111111;
    localparam logic [5:0] NO_T   = 6'b111110;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mr;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u2;
    logic       req;
    logic       fl;
    logic       dn;

    logic a_stall, a_pcw, a_ifw, a_start, a_busy, a_tout;
    logic b_stall, b_pcw, b_ifw, b_start, b_busy, b_tout;
`ifdef STALL_PERF_CNT_EN
    logic [31:0] a_scyc, b_scyc;
    logic [15:0] a_ops, b_ops;
    int unsigned m_stall;
    int unsigned m_ops;
`endif

    exp_t q[$];
    exp_t me;
    int   ncyc   = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.CGRA_TIMEOUT(8), .CNT_W(4)) dut_a (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .IDEX_MemRead_i (mr),
        .IDEX_Rd_i      (rd),
        .IFID_Rs1_i     (rs1),
        .IFID_Rs2_i     (rs2),
        .ID_UsesRs2_i   (u2),
        .cgra_req_i     (req),
        .flush_i        (fl),
        .cgra_done_i    (dn),
        .Stall_o        (a_stall),
        .PCWrite_o      (a_pcw),
        .IFIDWrite_o    (a_ifw),
        .cgra_start_o   (a_start),
        .cgra_busy_o    (a_busy),
        .timeout_o      (a_tout)
`ifdef STALL_PERF_CNT_EN
        ,
        .stall_cycles_o (a_scyc),
        .cgra_ops_o     (a_ops)
`endif
    );

    pipe_stall_ctrl dut_b (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .IDEX_MemRead_i (mr),
        .IDEX_Rd_i      (rd),
        .IFID_Rs1_i     (rs1),
        .IFID_Rs2_i     (rs2),
        .ID_UsesRs2_i   (u2),
        .cgra_req_i     (req),
        .flush_i        (fl),
        .cgra_done_i    (dn),
        .Stall_o        (b_stall),
        .PCWrite_o      (b_pcw),
        .IFIDWrite_o    (b_ifw),
        .cgra_start_o   (b_start),
        .cgra_busy_o    (b_busy),
        .timeout_o      (b_tout)
`ifdef STALL_PERF_CNT_EN
        ,
        .stall_cycles_o (b_scyc),
        .cgra_ops_o     (b_ops)
`endif
    );

    wire [5:0] oa = {a_stall, a_pcw, a_ifw, a_start, a_busy, a_tout};
    wire [5:0] ob = {b_stall, b_pcw, b_ifw, b_start, b_busy, b_tout};

    task automatic cyc(input in_t v, input logic [5:0] ea,
                       input logic [5:0] eb, input logic [5:0] m,
                       input bit act, input bit clr, input bit chk);
        exp_t e;
        @(posedge clk);
        #1;
        rst   = v.rst;
        start = v.start;
        mr    = v.mr;
        rd    = v.rd;
        rs1   = v.rs1;
        rs2   = v.rs2;
        u2    = v.u2;
        req   = v.req;
        fl    = v.fl;
        dn    = v.dn;
        e.id  = ncyc;
        e.ea  = ea;
        e.eb  = eb;
        e.m   = m;
        e.act = act;
        e.clr = clr;
        e.chk = chk;
        q.push_back(e);
        ncyc++;
    endtask

    task automatic c1(input in_t v, input logic [5:0] e);
        cyc(v, e, e, ALL, 1'b1, 1'b0, 1'b0);
    endtask

    // monitor: pops one expectation per cycle, away from the posedge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            checks++;
            if (((oa ^ me.ea) & me.m) !== 6'b0) begin
                errors++;
                $display("FAIL out_a cyc=%0d got=%b want=%b mask=%b",
                         me.id, oa, me.ea, me.m);
            end
            checks++;
            if (((ob ^ me.eb) & me.m) !== 6'b0) begin
                errors++;
                $display("FAIL out_b cyc=%0d got=%b want=%b mask=%b",
                         me.id, ob, me.eb, me.m);
            end
`ifdef STALL_PERF_CNT_EN
            if (me.clr) begin
                m_stall = 0;
                m_ops   = 0;
            end
            if (me.chk) begin
                checks++;
                if (a_scyc !== 32'(m_stall)) begin
                    errors++;
                    $display("FAIL stall_cycles cyc=%0d got=%0d want=%0d",
                             me.id, a_scyc, m_stall);
                end
                checks++;
                if (a_ops !== 16'(m_ops)) begin
                    errors++;
                    $display("FAIL cgra_ops cyc=%0d got=%0d want=%0d",
                             me.id, a_ops, m_ops);
                end
            end
            if (me.act && me.ea[5]) m_stall++;
            if (me.ea[2]) m_ops++;
`endif
        end
    end

    initial begin
        in_t v;
        rst   = 1'b1;
        start = 1'b0;
        mr    = 1'b0;
        rd    = '0;
        rs1   = '0;
        rs2   = '0;
        u2    = 1'b0;
        req   = 1'b0;
        fl    = 1'b0;
        dn    = 1'b0;
`ifdef STALL_PERF_CNT_EN
        m_stall = 0;
        m_ops   = 0;
`endif

        // reset, then idle with start low
        v = '0;
        v.rst = 1'b1;
        cyc(v, V_IDLE, V_IDLE, ALL, 1'b0, 1'b1, 1'b1);
        v.rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(v, V_IDLE, V_IDLE, ALL, 1'b0, 1'b0, i == 0);
        end
        v.start = 1'b1;
        cyc(v, V_IDLE, V_IDLE, ALL, 1'b0, 1'b0, 1'b0);
        v = '0;
        c1(v, V_RUN);

        // load-use hazards
        v.mr = 1'b1; v.rd = 5'd5; v.rs1 = 5'd5;
        c1(v, V_FRZ);
        v = '0;
        c1(v, V_RUN);
        v.mr = 1'b1; v.rd = 5'd0; v.rs1 = 5'd0;
        c1(v, V_RUN);
        v.mr = 1'b1; v.rd = 5'd7; v.rs1 = 5'd1; v.rs2 = 5'd7;
        c1(v, V_RUN);
        v.u2 = 1'b1;
        c1(v, V_FRZ);
        v = '0;
        c1(v, V_RUN);

        // CGRA with done 10 cycles after launch; dut_a times out at 8
        v.req = 1'b1;
        c1(v, V_FRZ);
        v = '0;
        c1(v, V_CGS);
        for (int i = 0; i < 8; i++) c1(v, V_CGW);
        cyc(v, V_CGD | T, V_CGW, ALL, 1'b1, 1'b0, 1'b0);
        v.dn = 1'b1;
        cyc(v, V_RUN | T, V_CGW, ALL, 1'b1, 1'b0, 1'b0);
        v = '0;
        cyc(v, V_RUN | T, V_CGD, ALL, 1'b1, 1'b0, 1'b0);
        cyc(v, V_RUN | T, V_RUN, ALL, 1'b1, 1'b0, 1'b1);

        // next request clears the sticky timeout
        v.req = 1'b1;
        cyc(v, V_FRZ | T, V_FRZ, ALL, 1'b1, 1'b0, 1'b0);
        v = '0;
        cyc(v, V_CGS, V_CGS, NO_T, 1'b1, 1'b0, 1'b0);
        v.dn = 1'b1;
        c1(v, V_CGW);
        v = '0;
        c1(v, V_CGD);
        c1(v, V_RUN);

        // done already in CG_START skips CG_WAIT
        v.req = 1'b1;
        c1(v, V_FRZ);
        v = '0;
        v.dn = 1'b1;
        c1(v, V_CGS);
        v = '0;
        c1(v, V_CGD);
        c1(v, V_RUN);

        // done on the last wait cycle wins over timeout
        v.req = 1'b1;
        c1(v, V_FRZ);
        v = '0;
        c1(v, V_CGS);
        for (int i = 0; i < 7; i++) c1(v, V_CGW);
        v.dn = 1'b1;
        c1(v, V_CGW);
        v = '0;
        c1(v, V_CGD);
        c1(v, V_RUN);

        // flush suppresses the CGRA request but not load-use
        v.req = 1'b1; v.fl = 1'b1;
        c1(v, V_RUN);
        v.mr = 1'b1; v.rd = 5'd3; v.rs1 = 5'd3;
        c1(v, V_FRZ);
        v = '0;
        c1(v, V_RUN);

        // load-use defers CGRA by one cycle, then reset in CG_WAIT
        v.req = 1'b1; v.mr = 1'b1; v.rd = 5'd9;
        v.rs1 = 5'd2; v.rs2 = 5'd9; v.u2 = 1'b1;
        c1(v, V_FRZ);
        v.mr = 1'b0;
        c1(v, V_FRZ);
        v = '0;
        c1(v, V_CGS);
        cyc(v, V_CGW, V_CGW, ALL, 1'b1, 1'b0, 1'b1);
        v.rst = 1'b1;
        cyc(v, V_IDLE, V_IDLE, ALL, 1'b0, 1'b1, 1'b1);
        v.rst = 1'b0;
        cyc(v, V_IDLE, V_IDLE, ALL, 1'b0, 1'b0, 1'b1);

        repeat (2) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
